// File: rtl/inst_byte_assembler.sv
// inst_byte_assembler: pops prefetch-queue bytes and presents sized instructions to decode
// Ports: clk, reset (sync, active-high); q_data/q_empty in, q_pull out (combinational pop)
//        flush/flush_pc restart the assembler at a new PC
//        inst_valid/inst_ready handshake carrying inst_opcode/op1/op2/len/pc (all registered)
module inst_byte_assembler #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                BRK_LEN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        q_data,
    input  logic              q_empty,
    output logic              q_pull,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [7:0]        inst_opcode,
    output logic [7:0]        inst_op1,
    output logic [7:0]        inst_op2,
    output logic [1:0]        inst_len,
    output logic [ADDR_W-1:0] inst_pc
);
    typedef enum logic [1:0] {S_OP, S_OP1, S_OP2, S_OUT} state_t;
    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [7:0]        opcode_q, opcode_d, op1_q, op1_d, op2_q, op2_d;
    logic [1:0]        len_q, len_d, op_len;
    logic [ADDR_W-1:0] pc_q, pc_d;
    always_comb
        op_len = q_data == 8'h00 ? 2'(BRK_LEN) :
                 (q_data[3:0] == 4'h8 || q_data[3:0] == 4'hA || q_data == 8'h40 || q_data == 8'h60) ? 2'd1 :
                 (q_data[3:2] == 2'b11 || q_data[4:0] == 5'b11001 || q_data == 8'h20) ? 2'd3 : 2'd2;
    assign q_pull = !reset && !flush && !q_empty && state_q != S_OUT;
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        opcode_d = opcode_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        len_d    = len_q;
        pc_d     = pc_q;
        if (flush) begin
            state_d  = S_OP;
            valid_d  = 1'b0;
            opcode_d = '0;
            op1_d    = '0;
            op2_d    = '0;
            len_d    = '0;
            pc_d     = flush_pc;
        end else if (q_pull && state_q == S_OP) begin
            opcode_d = q_data;
            len_d    = op_len;
            op1_d    = '0;
            op2_d    = '0;
            state_d  = op_len == 2'd1 ? S_OUT : S_OP1;
            valid_d  = op_len == 2'd1;
        end else if (q_pull && state_q == S_OP1) begin
            op1_d   = q_data;
            state_d = len_q == 2'd2 ? S_OUT : S_OP2;
            valid_d = len_q == 2'd2;
        end else if (q_pull && state_q == S_OP2) begin
            op2_d   = q_data;
            state_d = S_OUT;
            valid_d = 1'b1;
        end else if (state_q == S_OUT && inst_ready) begin
            pc_d    = pc_q + ADDR_W'(len_q);
            state_d = S_OP;
            valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_OP;
            valid_q  <= 1'b0;
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            len_q    <= '0;
            pc_q     <= RESET_PC;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            len_q    <= len_d;
            pc_q     <= pc_d;
        end
    end
    assign inst_valid  = valid_q;
    assign inst_opcode = opcode_q;
    assign inst_op1    = op1_q;
    assign inst_op2    = op2_q;
    assign inst_len    = len_q;
    assign inst_pc     = pc_q;
endmodule

// File: tb/tb_inst_byte_assembler.sv
// tb_inst_byte_assembler: table-driven and directed scoreboard bench for inst_byte_assembler
module tb_inst_byte_assembler;
    logic        clk, reset, q_empty, q_pull, flush, inst_valid, inst_ready;
    logic [7:0]  q_data, inst_opcode, inst_op1, inst_op2;
    logic [1:0]  inst_len;
    logic [15:0] flush_pc, inst_pc;

    inst_byte_assembler dut (
        .clk(clk), .reset(reset), .q_data(q_data), .q_empty(q_empty), .q_pull(q_pull),
        .flush(flush), .flush_pc(flush_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_opcode(inst_opcode), .inst_op1(inst_op1), .inst_op2(inst_op2),
        .inst_len(inst_len), .inst_pc(inst_pc)
    );

    typedef struct { logic [7:0] op, a, b; logic [1:0] len; } vec_t;
    typedef struct { logic [7:0] op, a, b; logic [1:0] len; logic [15:0] pc; } exp_t;

    vec_t        tbl [20];
    logic [7:0]  bq [$];
    exp_t        sb [$];
    logic [15:0] exp_pc, ep;
    int          n_vec, n_err;
    bit          rdy_rand, stall_rand, stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive_q();
        q_empty = stall || bq.size() == 0;
        q_data  = bq.size() != 0 ? bq[0] : 8'hFF;
    endtask

    task automatic add_exp(input logic [7:0] op, a, b, input logic [1:0] len);
        sb.push_back('{op, len >= 2'd2 ? a : 8'h00, len == 2'd3 ? b : 8'h00, len, exp_pc});
        exp_pc = exp_pc + 16'(len);
    endtask

    task automatic push_inst(input logic [7:0] op, a, b, input logic [1:0] len);
        bq.push_back(op);
        if (len >= 2'd2) bq.push_back(a);
        if (len == 2'd3) bq.push_back(b);
        add_exp(op, a, b, len);
        drive_q();
    endtask

    task automatic cycle();
        exp_t e;
        bit   pulled;
        @(negedge clk);
        if (q_pull && q_empty) begin
            n_vec++; n_err++;
            $display("FAIL pull_while_empty got=1 exp=0 t=%0t", $time);
        end
        if (inst_valid && inst_ready && !flush && !reset) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_inst got op=%h pc=%h exp=none", inst_opcode, inst_pc);
            end else begin
                e = sb.pop_front();
                chk("opcode", 32'(inst_opcode), 32'(e.op));
                chk("op1",    32'(inst_op1),    32'(e.a));
                chk("op2",    32'(inst_op2),    32'(e.b));
                chk("len",    32'(inst_len),    32'(e.len));
                chk("pc",     32'(inst_pc),     32'(e.pc));
            end
        end
        pulled = q_pull;
        @(posedge clk);
        #1;
        if (pulled && bq.size() != 0) void'(bq.pop_front());
        if (stall_rand) stall = $urandom_range(0, 3) == 0;
        if (rdy_rand) inst_ready = 1'($urandom_range(0, 1));
        drive_q();
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while (sb.size() != 0 && i < budget) begin
            cycle();
            i++;
        end
        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout got=%0d pending exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_valid(input int budget);
        int i = 0;
        while (!inst_valid && i < budget) begin
            cycle();
            i++;
        end
        chk("wait_valid", 32'(inst_valid), 32'd1);
    endtask

    initial begin
        tbl[0]  = '{8'hA9, 8'h05, 8'h00, 2'd2};
        tbl[1]  = '{8'h4C, 8'h34, 8'h12, 2'd3};
        tbl[2]  = '{8'hEA, 8'hCC, 8'hCC, 2'd1};
        tbl[3]  = '{8'h8D, 8'h00, 8'h02, 2'd3};
        tbl[4]  = '{8'h20, 8'h00, 8'h80, 2'd3};
        tbl[5]  = '{8'h60, 8'hCC, 8'hCC, 2'd1};
        tbl[6]  = '{8'h40, 8'hCC, 8'hCC, 2'd1};
        tbl[7]  = '{8'h00, 8'hCC, 8'hCC, 2'd1};
        tbl[8]  = '{8'h18, 8'hCC, 8'hCC, 2'd1};
        tbl[9]  = '{8'h19, 8'h10, 8'h20, 2'd3};
        tbl[10] = '{8'hB9, 8'hFF, 8'h01, 2'd3};
        tbl[11] = '{8'h11, 8'h22, 8'hCC, 2'd2};
        tbl[12] = '{8'h0A, 8'hCC, 8'hCC, 2'd1};
        tbl[13] = '{8'hFF, 8'hAA, 8'h55, 2'd3};
        tbl[14] = '{8'h02, 8'h77, 8'hCC, 2'd2};
        tbl[15] = '{8'h85, 8'h44, 8'hCC, 2'd2};
        tbl[16] = '{8'h6C, 8'h00, 8'h30, 2'd3};
        tbl[17] = '{8'h31, 8'h66, 8'hCC, 2'd2};
        tbl[18] = '{8'h79, 8'h34, 8'h12, 2'd3};
        tbl[19] = '{8'h38, 8'hCC, 8'hCC, 2'd1};
        n_vec = 0; n_err = 0;
        rdy_rand = 0; stall_rand = 0; stall = 0;
        reset = 1; flush = 0; flush_pc = '0; inst_ready = 1;
        exp_pc = 16'h0000;
        // reset with bytes already waiting: nothing may be pulled
        push_inst(8'hA9, 8'h05, 8'h00, 2'd2);
        repeat (3) cycle();
        chk("rst_valid",  32'(inst_valid),  32'd0);
        chk("rst_opcode", 32'(inst_opcode), 32'd0);
        chk("rst_op1",    32'(inst_op1),    32'd0);
        chk("rst_op2",    32'(inst_op2),    32'd0);
        chk("rst_len",    32'(inst_len),    32'd0);
        chk("rst_pc",     32'(inst_pc),     32'h0000);
        chk("rst_pull",   32'(q_pull),      32'd0);
        reset = 0;
        drain(50);
        // 3-byte then 1-byte instruction back to back
        push_inst(8'h4C, 8'h34, 8'h12, 2'd3);
        push_inst(8'hEA, 8'h00, 8'h00, 2'd1);
        drain(50);
        // queue runs dry mid-instruction
        add_exp(8'h8D, 8'h00, 8'h02, 2'd3);
        bq.push_back(8'h8D); bq.push_back(8'h00); drive_q();
        repeat (2) cycle();
        repeat (5) begin
            cycle();
            chk("starve_valid",  32'(inst_valid),  32'd0);
            chk("starve_opcode", 32'(inst_opcode), 32'h8D);
        end
        bq.push_back(8'h02); drive_q();
        drain(50);
        // decoder back-pressure with more bytes waiting
        ep = exp_pc;
        inst_ready = 0;
        push_inst(8'hEA, 8'h00, 8'h00, 2'd1);
        wait_valid(20);
        push_inst(8'h18, 8'h00, 8'h00, 2'd1);
        repeat (4) begin
            #1;
            chk("hold_valid",  32'(inst_valid),  32'd1);
            chk("hold_opcode", 32'(inst_opcode), 32'hEA);
            chk("hold_pc",     32'(inst_pc),     32'(ep));
            chk("hold_pull",   32'(q_pull),      32'd0);
            cycle();
        end
        inst_ready = 1;
        drain(50);
        // flush after opcode 20 pulled, next opcode already queued
        bq.push_back(8'h20); drive_q();
        repeat (3) cycle();
        bq.push_back(8'hEA); drive_q();
        flush = 1; flush_pc = 16'hC000;
        #1 chk("flush_pull", 32'(q_pull), 32'd0);
        cycle();
        flush = 0;
        #1;
        chk("flush_valid",  32'(inst_valid),  32'd0);
        chk("flush_pc",     32'(inst_pc),     32'hC000);
        chk("flush_opcode", 32'(inst_opcode), 32'd0);
        exp_pc = 16'hC000;
        add_exp(8'hEA, 8'h00, 8'h00, 2'd1);
        drain(50);
        // flush wins over a same-cycle handshake
        inst_ready = 0;
        bq.push_back(8'h18); drive_q();
        wait_valid(20);
        inst_ready = 1; flush = 1; flush_pc = 16'h1234;
        cycle();
        flush = 0;
        #1;
        chk("flushhs_valid", 32'(inst_valid), 32'd0);
        chk("flushhs_pc",    32'(inst_pc),    32'h1234);
        // reset while waiting for the second operand
        bq.push_back(8'h4C); bq.push_back(8'h34); drive_q();
        repeat (3) cycle();
        bq.push_back(8'h60); drive_q();
        reset = 1;
        #1 chk("rstmid_pull", 32'(q_pull), 32'd0);
        cycle();
        reset = 0;
        #1;
        chk("rstmid_valid", 32'(inst_valid), 32'd0);
        chk("rstmid_pc",    32'(inst_pc),    32'h0000);
        chk("rstmid_len",   32'(inst_len),   32'd0);
        exp_pc = 16'h0000;
        add_exp(8'h60, 8'h00, 8'h00, 2'd1);
        drain(50);
        // pc wrap FFFF + 2 -> 0001
        flush = 1; flush_pc = 16'hFFFF;
        cycle();
        flush = 0;
        exp_pc = 16'hFFFF;
        push_inst(8'hA9, 8'h05, 8'h00, 2'd2);
        push_inst(8'hEA, 8'h00, 8'h00, 2'd1);
        drain(50);
        // full table with random back-pressure and queue stalls
        rdy_rand = 1; stall_rand = 1;
        for (int i = 0; i < 20; i++) push_inst(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].len);
        drain(3000);
        rdy_rand = 0; stall_rand = 0; stall = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
